// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply-accumulate / restoring-divide unit for the EX stage.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU return zero after two cycles.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic               annul,
  output logic               stallreq,
  output logic               done,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy
);

  localparam logic [2:0] OP_MADD  = 3'd0;
  localparam logic [2:0] OP_MADDU = 3'd1;
  localparam logic [2:0] OP_MSUB  = 3'd2;
  localparam logic [2:0] OP_MSUBU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  typedef enum logic [2:0] {IDLE, MACC, DIVRUN, DIVZERO, DONE} state_t;

  if ((1 << CNT_W) <= WIDTH) begin : g_cnt_w_check
    $error("ex_muldiv: CNT_W too small to count WIDTH divide steps");
  end

  state_t             state;
  logic               done_r;
  logic [2*WIDTH-1:0] result_r;
  logic [2*WIDTH-1:0] hilo_r;
  logic [2*WIDTH-1:0] prod_r;
  logic               sub_r;

  logic               op_legal;
  logic               is_div;
  logic               is_signed;
  logic               accept;
  logic [2*WIDTH-1:0] m1;
  logic [2*WIDTH-1:0] m2;

  assign op_legal  = !(op[2] && op[1]);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  assign accept    = (state == IDLE) && start && !annul && op_legal;

  // Sign- or zero-extend to 2*WIDTH so one truncated multiply serves both signednesses.
  assign m1 = {{WIDTH{is_signed & opdata1[WIDTH-1]}}, opdata1};
  assign m2 = {{WIDTH{is_signed & opdata2[WIDTH-1]}}, opdata2};

  assign stallreq = start && op_legal && !done_r && !annul && !rst;
  assign done     = done_r;
  assign result_o = result_r;
  assign busy     = (state != IDLE);

`ifdef MULDIV_DIV_EN
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] div_q, div_r, div_d;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_next, r_next;

  assign mag1 = (is_signed && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign mag2 = (is_signed && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    shifted = {div_r, div_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_d};
    r_next  = shifted[WIDTH-1:0];
    q_next  = {div_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      r_next = diff[WIDTH-1:0];
      q_next = {div_q[WIDTH-2:0], 1'b1};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too, so result_o reads zero straight out of reset.
      state    <= IDLE;
      done_r   <= 1'b0;
      result_r <= '0;
      hilo_r   <= '0;
      prod_r   <= '0;
      sub_r    <= 1'b0;
`ifdef MULDIV_DIV_EN
      cnt      <= '0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (annul) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hilo_r <= {hi_i, lo_i};
            prod_r <= m1 * m2;
            sub_r  <= (op == OP_MSUB) || (op == OP_MSUBU);
            if (!is_div) begin
              state <= MACC;
`ifdef MULDIV_DIV_EN
            end else if (opdata2 == '0) begin
              state <= DIVZERO;
            end else begin
              state <= DIVRUN;
              cnt   <= '0;
              div_q <= mag1;
              div_r <= '0;
              div_d <= mag2;
              neg_q <= is_signed && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              neg_r <= is_signed && opdata1[WIDTH-1];
`endif
            end else begin
              state <= DIVZERO;
            end
          end
        end
        MACC: begin
          result_r <= sub_r ? (hilo_r - prod_r) : (hilo_r + prod_r);
          state    <= DONE;
          done_r   <= 1'b1;
        end
        DIVRUN: begin
`ifdef MULDIV_DIV_EN
          div_q <= q_next;
          div_r <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            // Signed fix-up: quotient sign from the operand signs, remainder follows the dividend.
            result_r <= {(neg_r ? -r_next : r_next), (neg_q ? -q_next : q_next)};
            state    <= DONE;
            done_r   <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        DIVZERO: begin
          result_r <= '0;
          state    <= DONE;
          done_r   <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected {HI,LO} and latency are queued at drive time and
// popped by a monitor on each done strobe; divider expectations follow MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_ex_muldiv;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int ANNUL_AT = DIV_EN ? 10 : 1;
  localparam int RST_AT   = DIV_EN ? 5 : 1;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
    int             acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, annul;
  logic [2:0]     op;
  logic [W-1:0]   opdata1, opdata2, hi_i, lo_i;
  logic           stallreq, done, busy;
  logic [2*W-1:0] result_o;

  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  exp_t           exp_q[$];
  logic [2*W-1:0] last_res;

  ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opdata1(opdata1), .opdata2(opdata2), .hi_i(hi_i), .lo_i(lo_i),
    .annul(annul), .stallreq(stallreq), .done(done), .result_o(result_o), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, b, h, l);
    exp_t        e;
    logic [63:0] hl, p;
    longint      sa, sb;
    int          da, db;
    hl    = {h, l};
    e.lat = 2;
    e.res = '0;
    e.acc = 0;
    case (o)
      3'd0, 3'd2: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        e.res = (o == 3'd0) ? hl + p : hl - p;
      end
      3'd1, 3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        e.res = (o == 3'd1) ? hl + p : hl - p;
      end
      3'd4: begin
        if (DIV_EN && b != 0) begin
          e.lat = W + 1;
          da = $signed(a);
          db = $signed(b);
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = {32'h0, 32'h8000_0000};
          else e.res = {32'(da % db), 32'(da / db)};
        end
      end
      3'd5: begin
        if (DIV_EN && b != 0) begin
          e.lat = W + 1;
          e.res = {a % b, a / b};
        end
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result_o, e.res);
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Starts one operation on the next negedge and holds start until done is seen.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, b, h, l);
    exp_t e;
    bit   seen;
    @(negedge clk);
    op = o; opdata1 = a; opdata2 = b; hi_i = h; lo_i = l; start = 1'b1;
    e = model(o, a, b, h, l);
    e.acc = cyc;
    last_res = e.res;
    exp_q.push_back(e);
    #1 check("stall_accept", stallreq, 1);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("stall_busy", stallreq, 1);
    end
    if (seen) check("stall_done", stallreq, 0);
    else begin
      check("timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    start = 1'b0;
  endtask

  // Starts an operation, then cancels it k cycles after accept with annul or rst.
  task automatic abort_op(input logic [2:0] o, input logic [W-1:0] a, b, input int k, input bit use_rst);
    @(negedge clk);
    op = o; opdata1 = a; opdata2 = b; hi_i = '0; lo_i = '0; start = 1'b1;
    repeat (k) @(negedge clk);
    check("abort_running", busy, 1);
    if (use_rst) rst = 1'b1;
    else annul = 1'b1;
    #1 check("abort_stall", stallreq, 0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    if (use_rst) check("abort_result", result_o, 0);
    rst = 1'b0; annul = 1'b0; start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; annul = 1'b0; op = 3'd0;
    opdata1 = '0; opdata2 = '0; hi_i = '0; lo_i = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result_o, 0);
    check("rst_stall", stallreq, 0);
    rst = 1'b0; start = 1'b0;

    do_op(3'd0, 32'd3, 32'd4, 32'd0, 32'd5);
    @(negedge clk);
    check("result_hold", result_o, last_res);
    do_op(3'd2, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
    do_op(3'd3, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    do_op(3'd5, 32'd100, 32'd7, 32'd0, 32'd0);
    do_op(3'd5, 32'd100, 32'd0, 32'd0, 32'd0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    do_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0);

    for (int i = 6; i < 8; i++) begin
      @(negedge clk);
      op = 3'(i); opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1;
      #1 check("illegal_stall", stallreq, 0);
      @(negedge clk);
      check("illegal_busy", busy, 0);
      start = 1'b0;
    end

    abort_op(3'd4, 32'd1000, 32'd3, ANNUL_AT, 1'b0);
    do_op(3'd0, 32'd6, 32'd7, 32'd1, 32'd2);
    abort_op(3'd0, 32'd5, 32'd5, 1, 1'b0);
    do_op(3'd2, 32'd2, 32'd2, 32'd0, 32'd10);
    abort_op(3'd4, 32'd1000, 32'd3, RST_AT, 1'b1);
    do_op(3'd5, 32'd100, 32'd7, 32'd0, 32'd0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(ro, $urandom, rb, $urandom, $urandom);
    end

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand width; result width 2*WIDTH.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; held high by the pipeline until done is seen.
REQ-006 op  input  3  0=MADD, 1=MADDU, 2=MSUB, 3=MSUBU, 4=DIV, 5=DIVU; 6 and 7 are illegal.
REQ-007 opdata1  input  WIDTH  multiplicand or dividend.
REQ-008 opdata2  input  WIDTH  multiplier or divisor.
REQ-009 hi_i, lo_i  input  WIDTH each  forwarded HI/LO accumulator, sampled at accept.
REQ-010 annul  input  1  cancel the in-flight operation (flush).
REQ-011 stallreq  output  1  pipeline stall request.
REQ-012 done  output  1  single-cycle completion strobe.
REQ-013 result_o  output  2*WIDTH  {HI,LO} result, valid while done=1.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 States SHALL be IDLE, MACC, DIVRUN, DIVZERO, DONE.
REQ-016 Accept: state IDLE, start=1, annul=0, op legal; opdata1, opdata2, hi_i, lo_i, op registered on that edge.
REQ-017 Illegal op in IDLE: SHALL NOT be accepted; stallreq=0; no state change.
REQ-018 MADD/MSUB (signed) and MADDU/MSUBU (unsigned) transitions: IDLE->MACC on accept, with the 2*WIDTH product registered.
REQ-019 MADD/MSUB accumulate: in MACC, {HI,LO} +/- product computed modulo 2^(2*WIDTH); state then ->DONE; done at accept+2.
REQ-020 DIV/DIVU with divisor nonzero: IDLE->DIVRUN; restoring radix-2, one quotient bit per cycle, exactly WIDTH cycles; ->DONE; done at accept+WIDTH+1.
REQ-021 Signed divide: operates on magnitudes; quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-022 Divide result: result_o={remainder,quotient}.
REQ-023 Divisor zero: IDLE->DIVZERO->DONE; result_o all zeros; done at accept+2.
REQ-024 DONE: done=1 and result_o valid for exactly one cycle, then ->IDLE unconditionally.
REQ-025 result_o SHALL hold its last value outside DONE.
REQ-026 Back-to-back: start=1 in the cycle after DONE is a new accept; no bubble beyond the IDLE cycle.
REQ-027 stallreq = start & legal op & ~done & ~annul, combinational.
REQ-028 annul=1 in any state: ->IDLE on the next edge; done is not asserted; annul has priority over start and over completion.
REQ-029 MIN-signed / -1 divide: quotient = MIN-signed (wraps); remainder 0; no exception.

Reset
REQ-030 rst=1 on an edge: state=IDLE, counter=0, all datapath registers=0, result_o=0, done=0, busy=0; stallreq=0 while rst=1.
REQ-031 rst mid-operation SHALL abandon the operation with no done strobe.

Configuration
REQ-032 Macro MULDIV_DIV_EN defined: divider datapath compiled in; DIV/DIVU behave per REQ-020 to REQ-023 and REQ-029.
REQ-033 Macro MULDIV_DIV_EN undefined: no divider logic; DIV/DIVU take the DIVZERO path (zero result, done at accept+2) for every divisor.

Verification
REQ-034 Scenario: WIDTH=32, MADD, hi_i=0, lo_i=5, opdata1=3, opdata2=4 -> done at accept+2 with result_o=0x00000000_00000011; stallreq high for accept and MACC cycles only.
REQ-035 Scenario: MSUB, hi_i:lo_i=0, opdata1=0xFFFFFFFE, opdata2=3 -> result_o=0x00000000_00000006 at accept+2; as MSUBU -> result_o=0xFFFFFFFD_00000006.
REQ-036 Scenario: DIV, opdata1=0xFFFFFFF9 (-7), opdata2=2 -> done at accept+33 with result_o=0xFFFFFFFF_FFFFFFFD; DIVU 100/7 -> 0x00000002_0000000E.
REQ-037 Scenario: DIVU, opdata2=0 -> done at accept+2 with result_o=0; build without MULDIV_DIV_EN, DIV 100/7 -> result_o=0 at accept+2.
REQ-038 Scenario: DIV accepted, annul=1 at accept+10 -> no done, busy=0 next cycle; a MADD start the following cycle is accepted and completes normally.
REQ-039 Scenario: rst=1 at accept+5 of a DIV -> all outputs 0 next cycle, no done; the next start is accepted.
